myproject_mul_share_sched: RTL

//  Round-robin scheduler that time-shares one pipelined 16s x 11ns -> 27-bit multiplier

---
 rtl/myproject_mul_sched_pkg.sv | 13 +
 rtl/myproject_mul_share_sched_if.sv | 29 ++
 rtl/myproject_mul_16s_11ns_27.sv | 25 ++
 rtl/myproject_rr_arb.sv | 29 ++
 rtl/myproject_mul_share_sched.sv | 80 ++++++++
 5 files changed

// File: rtl/myproject_mul_sched_pkg.sv
// Shared widths and tag type for the shared-multiplier scheduler.
// Pure declarations; no latency or backpressure of its own.
package myproject_mul_sched_pkg;
  localparam int A_W      = 16;
  localparam int B_W      = 11;
  localparam int P_W      = 27;
  localparam int ID_MAX_W = 4;

  typedef struct packed {
    logic                v;
    logic [ID_MAX_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/myproject_mul_share_sched_if.sv
// Request/result bundle of the shared-multiplier scheduler.
// Valid/ready on both channels; slave is the scheduler, master the lanes plus consumer.
interface myproject_mul_share_sched_if
  import myproject_mul_sched_pkg::*;
#(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*A_W-1:0] req_a;
  logic [NREQ*B_W-1:0] req_b;
  logic                res_valid;
  logic                res_ready;
  logic [P_W-1:0]      res_data;
  logic [IDW-1:0]      res_id;
  logic                busy;

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id, busy
  );

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/myproject_mul_16s_11ns_27.sv
// Signed 16 x unsigned 11 -> 27-bit exact multiplier, MUL_LAT ce-gated register stages.
// ce low holds every stage; datapath registers carry no reset.
module myproject_mul_16s_11ns_27 #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        ce,
  input  logic [15:0] din0,
  input  logic [10:0] din1,
  output logic [26:0] dout
);
  logic signed [26:0] prod;
  logic        [26:0] pipe [MUL_LAT];

  assign prod = $signed({{11{din0[15]}}, din0}) * $signed({16'b0, din1});

  always_ff @(posedge clk) begin
    if (ce) begin
      pipe[0] <= prod;
      for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[MUL_LAT-1];
endmodule

// File: rtl/myproject_rr_arb.sv
// Round-robin pick of the first set req at or after ptr; purely combinational.
// en low forces no grant, which is how the scheduler blocks intake while stalled.
module myproject_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gidx,
  output logic            any
);
  always_comb begin
    int j;
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (en && !any && req[j]) begin
        grant[j] = 1'b1;
        gidx     = IDW'(j);
        any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/myproject_mul_share_sched.sv
// Round-robin time-sharing of one pipelined multiplier across NREQ lanes, id-tagged results.
// Latency MUL_LAT cycles; a held result (res_valid & ~res_ready) freezes the whole pipe.
module myproject_mul_share_sched
  import myproject_mul_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 1
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  myproject_mul_share_sched_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);

  logic            ce;
  logic            arb_en;
  logic            any;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic [IDW-1:0]  ptr;
  logic [A_W-1:0]  din0;
  logic [B_W-1:0]  din1;
  logic [P_W-1:0]  dout;
  tag_t            tags [MUL_LAT];
  tag_t            last_tag;
  logic            busy_c;

  assign last_tag = tags[MUL_LAT-1];
  assign ce       = ~(last_tag.v & ~bus.res_ready);
  // Intake is also closed during reset so nothing is granted into a pipe being cleared.
  assign arb_en   = ce & ap_rst_n;

  myproject_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .en    (arb_en),
    .grant (grant),
    .gidx  (gidx),
    .any   (any)
  );

  assign din0 = bus.req_a[A_W*int'(gidx) +: A_W];
  assign din1 = bus.req_b[B_W*int'(gidx) +: B_W];

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      ptr <= '0;
    end else if (ce && any) begin
      ptr <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + IDW'(1);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) tags[i] <= '0;
    end else if (ce) begin
      tags[0] <= '{v: any, id: ID_MAX_W'(gidx)};
      for (int i = 1; i < MUL_LAT; i++) tags[i] <= tags[i-1];
    end
  end

  myproject_mul_16s_11ns_27 #(.MUL_LAT(MUL_LAT)) u_mul (
    .clk  (ap_clk),
    .ce   (ce),
    .din0 (din0),
    .din1 (din1),
    .dout (dout)
  );

  always_comb begin
    busy_c = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) busy_c = busy_c | tags[i].v;
  end

  assign bus.req_ready = grant;
  assign bus.res_valid = last_tag.v;
  assign bus.res_id    = IDW'(last_tag.id);
  assign bus.res_data  = dout;
  assign bus.busy      = busy_c;
endmodule
